// File: rtl/param_word_buffer.sv
// Word buffer that loads DEPTH words of WIDTH bits through a valid/ready port.
// Once full, it holds the words and can rotate them one word per cycle on request.
module param_word_buffer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   rot_en,
  output logic [WIDTH*DEPTH-1:0] words_flat,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   load_done
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]             state;
  logic [PW-1:0]          ptr;
  logic [WIDTH*DEPTH-1:0] words_q;

  assign in_ready   = (state == LOAD);
  assign words_flat = words_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      ptr       <= '0;
      count     <= '0;
      full      <= 1'b0;
      load_done <= 1'b0;
      words_q   <= '0;
    end else if (clr) begin
      state     <= LOAD;
      ptr       <= '0;
      count     <= '0;
      full      <= 1'b0;
      load_done <= 1'b0;
      words_q   <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            words_q[ptr*WIDTH +: WIDTH] <= in_data;
            count <= count + 1'b1;
            if (count == CW'(DEPTH - 1)) begin
              ptr       <= '0;
              full      <= 1'b1;
              load_done <= 1'b1;
              state     <= HOLD;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        HOLD: begin
          // Word i takes word i+1; word 0 wraps to the top slot.
          if (rot_en) begin
            words_q <= {words_q[WIDTH-1:0], words_q[WIDTH*DEPTH-1:WIDTH]};
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
